keypad_scan: RTL and testbench

- Drives a 4x4 matrix keypad and produces the debounced direction vector `mov[3:0]` (u d l r) that the character-motion logic consumes.
- Also reports newly pressed keys as a one-cycle strobe with a 4-bit key code, for menu and start logic.
- Sits between the board keypad pins and the game calculation blocks, all on `sys_clk`.

---
 rtl/keypad_scan.sv | 143 ++++++++++++++
 tb/tb_keypad_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchronisation, frame debounce,
// direction decode and new-press strobe with lowest-index key code.
module keypad_scan #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [3:0]  mov,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] pressed
);

    localparam int unsigned   CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned   DebW   = $clog2(DEB_FRAMES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_FRAMES);

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      w_row_act;
    logic [CntW-1:0] r_cnt;
    logic            w_tick;
    logic [1:0]      r_col;
    logic [1:0]      w_col_next;
    logic [3:0]      r_col_n;
    logic [15:0]     r_snap;
    logic [15:0]     w_snap_next;
    logic [15:0]     r_prev;
    logic [DebW-1:0] r_stable;
    logic [DebW-1:0] w_stable_next;
    logic            w_frame_end;
    logic [15:0]     r_pressed;
    logic [15:0]     r_pressed_prev;
    logic [15:0]     w_new;
    logic [3:0]      w_low_idx;
    logic [3:0]      r_mov;
    logic            r_key_valid;
    logic [3:0]      r_key_code;

    // Rows are asynchronous to sys_clk; idle (released) level is all-ones.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_row_act  = ~r_sync2;
    assign w_tick     = (r_cnt == CntMax);
    assign w_col_next = r_col + 2'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt   <= '0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_col   <= w_col_next;
            r_col_n <= ~(4'b0001 << w_col_next);
        end else begin
            r_cnt   <= r_cnt + CntW'(1);
        end
    end

    // Snapshot with the current column's rows merged in; at frame end this is the full frame.
    always_comb begin
        w_snap_next = r_snap;
        for (int r = 0; r < 4; r++) begin
            w_snap_next[{r[1:0], r_col}] = w_row_act[r];
        end
    end

    assign w_frame_end = w_tick && (r_col == 2'd3);

    always_comb begin
        if (w_snap_next == r_prev) begin
            w_stable_next = (r_stable == DebMax) ? r_stable : r_stable + DebW'(1);
        end else begin
            w_stable_next = DebW'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_snap    <= '0;
            r_prev    <= '0;
            r_stable  <= '0;
            r_pressed <= '0;
        end else if (w_tick) begin
            r_snap <= w_snap_next;
            if (w_frame_end) begin
                r_prev   <= w_snap_next;
                r_stable <= w_stable_next;
                if (w_stable_next == DebMax) begin
                    r_pressed <= w_snap_next;
                end
            end
        end
    end

    assign w_new = r_pressed & ~r_pressed_prev;

    always_comb begin
        w_low_idx = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (w_new[k]) begin
                w_low_idx = 4'(k);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pressed_prev <= '0;
            r_mov          <= 4'd0;
            r_key_valid    <= 1'b0;
            r_key_code     <= 4'd0;
        end else begin
            r_pressed_prev <= r_pressed;
            // Keys '2','8','4','6' map to up, down, left, right.
            r_mov          <= {r_pressed[1], r_pressed[9], r_pressed[4], r_pressed[6]};
            r_key_valid    <= |w_new;
            if (|w_new) begin
                r_key_code <= w_low_idx;
            end
        end
    end

    assign col_n     = r_col_n;
    assign mov       = r_mov;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign pressed   = r_pressed;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, vector table for steady key sets,
// strobe scoreboard, and hand-written bounce / mid-frame reset sequences.
module tb_keypad_scan;

    localparam int unsigned ScanDiv   = 4;
    localparam int unsigned DebFrames = 3;
    localparam int          Settle    = 96;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  mov;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] pressed;

    logic [15:0] keys;
    int          checks;
    int          failures;
    logic [3:0]  sb[$];

    typedef struct {
        logic [15:0] keys;
        logic [15:0] exp_pressed;
        logic [3:0]  exp_mov;
    } vec_t;

    vec_t vecs[10];

    keypad_scan #(
        .SCAN_DIV   (ScanDiv),
        .DEB_FRAMES (DebFrames)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .mov       (mov),
        .key_valid (key_valid),
        .key_code  (key_code),
        .pressed   (pressed)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // A held key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] idx = 4'd0;
        for (int k = 15; k >= 0; k--) if (v[k]) idx = 4'(k);
        return idx;
    endfunction

    // Every strobe must match the next queued expectation.
    always @(negedge sys_clk) begin
        if (sys_rst_n && key_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {28'd0, key_code}, 32'hFFFF_FFFF);
            end else begin
                check("strobe_code", {28'd0, key_code}, {28'd0, sb.pop_front()});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [15:0] prev_exp;
        logic [3:0]  last_code;

        vecs[0] = '{16'h0000, 16'h0000, 4'b0000};
        vecs[1] = '{16'h0040, 16'h0040, 4'b0001};
        vecs[2] = '{16'h0000, 16'h0000, 4'b0000};
        vecs[3] = '{16'h0012, 16'h0012, 4'b1010};
        vecs[4] = '{16'h0010, 16'h0010, 4'b0010};
        vecs[5] = '{16'h0000, 16'h0000, 4'b0000};
        vecs[6] = '{16'h8000, 16'h8000, 4'b0000};
        vecs[7] = '{16'h0000, 16'h0000, 4'b0000};
        vecs[8] = '{16'h0250, 16'h0250, 4'b0111};
        vecs[9] = '{16'h0000, 16'h0000, 4'b0000};

        checks    = 0;
        failures  = 0;
        keys      = 16'h0000;
        prev_exp  = 16'h0000;
        last_code = 4'd0;
        sys_rst_n = 1'b0;

        cycles(3);
        check("rst_col_n", {28'd0, col_n}, 32'hE);
        check("rst_mov", {28'd0, mov}, 32'h0);
        check("rst_pressed", {16'd0, pressed}, 32'h0);
        check("rst_key_valid", {31'd0, key_valid}, 32'h0);
        check("rst_key_code", {28'd0, key_code}, 32'h0);

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int p = 1; p <= 16; p++) begin
            logic [3:0] one;
            cycles(1);
            one = 4'b0001 << ((p / 4) % 4);
            check("col_n_seq", {28'd0, col_n}, {28'd0, ~one});
        end

        for (int i = 0; i < 10; i++) begin
            logic [15:0] fresh;
            fresh = vecs[i].exp_pressed & ~prev_exp;
            if (fresh != 16'h0000) begin
                last_code = lowest(fresh);
                sb.push_back(last_code);
            end
            keys = vecs[i].keys;
            cycles(Settle);
            check("vec_pressed", {16'd0, pressed}, {16'd0, vecs[i].exp_pressed});
            check("vec_mov", {28'd0, mov}, {28'd0, vecs[i].exp_mov});
            check("vec_key_code", {28'd0, key_code}, {28'd0, last_code});
            check("vec_sb_drained", sb.size(), 0);
            prev_exp = vecs[i].exp_pressed;
        end

        // Key '8' bouncing every 5 cycles for 4 frames, then held.
        for (int t = 0; t < 64; t++) begin
            if (t % 5 == 0) keys[9] = ~keys[9];
            cycles(1);
            check("bounce_pressed", {16'd0, pressed}, 32'h0);
        end
        keys = 16'h0200;
        sb.push_back(4'd9);
        cycles(Settle);
        check("bounce_pressed_final", {16'd0, pressed}, 32'h0200);
        check("bounce_mov", {28'd0, mov}, 32'h4);
        check("bounce_code", {28'd0, key_code}, 32'h9);
        keys = 16'h0000;
        cycles(Settle);

        // Mid-frame reset while '6' is held.
        keys = 16'h0040;
        sb.push_back(4'd6);
        cycles(Settle);
        check("pre_rst_mov", {28'd0, mov}, 32'h1);
        cycles(6);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_col_n", {28'd0, col_n}, 32'hE);
        check("midrst_mov", {28'd0, mov}, 32'h0);
        check("midrst_pressed", {16'd0, pressed}, 32'h0);
        check("midrst_key_code", {28'd0, key_code}, 32'h0);
        sb.push_back(4'd6);
        cycles(2);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cycles(40);
        check("postrst_mov_early", {28'd0, mov}, 32'h0);
        cycles(16);
        check("postrst_mov", {28'd0, mov}, 32'h1);
        check("postrst_pressed", {16'd0, pressed}, 32'h0040);
        keys = 16'h0000;
        cycles(Settle);
        check("final_sb_drained", sb.size(), 0);
        check("final_mov", {28'd0, mov}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
